// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, lever width and per-level balance tolerances
package game_pkg;
  typedef enum logic [2:0] {IDLE, ARM, LOAD, PLAY, WIN, LOSE} state_t;
  localparam int LEVER_W = 16;
  localparam logic [15:0] TOL_L0 = 16'd4096;
  localparam logic [15:0] TOL_L1 = 16'd2048;
  localparam logic [15:0] TOL_L2 = 16'd1024;
  localparam logic [15:0] TOL_L3 = 16'd512;
  function automatic logic [15:0] level_tol(input logic [1:0] lvl);
    return lvl == 2'd0 ? TOL_L0 : lvl == 2'd1 ? TOL_L1 : lvl == 2'd2 ? TOL_L2 : TOL_L3;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts 0..TICK_DIV-1 while enabled, one-cycle tick on wrap
module tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] count;
  assign tick = enable && count == W'(TICK_DIV - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/game_round_controller.sv
// game_round_controller: start handshake with the level register, then one timed balance round
module game_round_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 2000,
  parameter int ROUND_TICKS = 10000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic [1:0]         nivel,
  input  logic [LEVER_W-1:0] alavanca1,
  input  logic [LEVER_W-1:0] alavanca2,
  output logic               start_game,
  output logic               playing,
  output logic               win,
  output logic               lose,
  output logic [15:0]        hold_count,
  output logic [15:0]        time_left
);
  state_t state, state_next;
  logic start_prev, start_ev, tick, balanced;
  logic [15:0] tol, hold_next, time_next;
  logic [16:0] diff, mag;
  assign start_ev = start_btn && !start_prev;
  // 17-bit difference of sign-extended readings; magnitude always fits 16 bits
  assign diff = {alavanca1[15], alavanca1} - {alavanca2[15], alavanca2};
  assign mag = diff[16] ? 17'(-diff) : diff;
  assign balanced = mag <= {1'b0, tol};
  assign hold_next = balanced ? hold_count + 16'd1 : 16'd0;
  assign time_next = time_left - 16'd1;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (playing),
    .clear   (state == LOAD),
    .tick    (tick)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      tol        <= TOL_L0;
      hold_count <= '0;
      time_left  <= '0;
    end else begin
      state      <= state_next;
      start_prev <= start_btn;
      if (state == LOAD) begin
        tol        <= level_tol(nivel);
        hold_count <= '0;
        time_left  <= 16'(ROUND_TICKS);
      end else if (playing && tick) begin
        hold_count <= hold_next;
        time_left  <= time_next;
      end
    end
  always_comb begin
    state_next = state;
    start_game = state == ARM;
    playing    = state == PLAY;
    win        = state == WIN;
    lose       = state == LOSE;
    case (state)
      ARM:     state_next = LOAD;
      LOAD:    state_next = PLAY;
      PLAY:    if (tick) state_next = hold_next == 16'(HOLD_TICKS) ? WIN : time_next == 16'd0 ? LOSE : PLAY;
      default: if (start_ev) state_next = ARM;
    endcase
  end
endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed rounds checked against a round-level model plus literal expectations
module tb_game_round_controller;
  localparam int TICK_DIV = 4, HOLD = 3, ROUND = 10;
  logic clock = 1'b0, reset_n, start_btn;
  logic [1:0] nivel, level_sel;
  logic level_locked;
  logic [15:0] alavanca1, alavanca2, hold_count, time_left;
  logic start_game, playing, win, lose;
  int checks = 0, errors = 0, pulses = 0;
  string ph;
  int m_hold, m_time, m_pc, m_tol, m_d;
  bit m_prev, m_ev;

  game_round_controller #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD), .ROUND_TICKS(ROUND)) dut (
    .clock(clock), .reset_n(reset_n), .start_btn(start_btn), .nivel(nivel),
    .alavanca1(alavanca1), .alavanca2(alavanca2), .start_game(start_game),
    .playing(playing), .win(win), .lose(lose), .hold_count(hold_count), .time_left(time_left)
  );

  always #5 clock = ~clock;

  // level register: latches the selected level on the first start_game pulse, locked until reset
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      nivel <= 2'd0;
      level_locked <= 1'b0;
    end else if (start_game && !level_locked) begin
      nivel <= level_sel;
      level_locked <= 1'b1;
    end

  // round model: phases by name, ticks every TICK_DIV-th cycle spent playing
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ph = "IDLE"; m_hold = 0; m_time = 0; m_pc = 0; m_tol = 4096; m_prev = 0;
    end else begin
      m_ev = start_btn && !m_prev;
      m_prev = start_btn;
      if (ph == "IDLE" || ph == "WIN" || ph == "LOSE") begin
        if (m_ev) ph = "ARM";
      end else if (ph == "ARM") ph = "LOAD";
      else if (ph == "LOAD") begin
        m_tol = 4096 >> nivel; m_hold = 0; m_time = ROUND; m_pc = 0; ph = "PLAY";
      end else begin
        m_pc++;
        if (m_pc % TICK_DIV == 0) begin
          m_d = int'($signed(alavanca1)) - int'($signed(alavanca2));
          if (m_d < 0) m_d = -m_d;
          m_hold = m_d <= m_tol ? m_hold + 1 : 0;
          m_time--;
          if (m_hold == HOLD) ph = "WIN";
          else if (m_time == 0) ph = "LOSE";
        end
      end
    end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (start_game) pulses++;
    chk("m_start_game", start_game, ph == "ARM");
    chk("m_playing", playing, ph == "PLAY");
    chk("m_win", win, ph == "WIN");
    chk("m_lose", lose, ph == "LOSE");
    chk("m_hold_count", hold_count, m_hold);
    chk("m_time_left", time_left, m_time);
  end

  function automatic bit sig(input int which);
    case (which)
      0: return start_game;
      1: return playing;
      2: return win;
      3: return lose;
      4: return playing && time_left == 16'd3;
      default: return win || lose;
    endcase
  endfunction

  task automatic wait_until(input int which, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (sig(which)) break;
      @(negedge clock);
    end
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, "_start_game"}, start_game, 0);
    chk({nm, "_playing"}, playing, 0);
    chk({nm, "_win"}, win, 0);
    chk({nm, "_lose"}, lose, 0);
    chk({nm, "_hold"}, hold_count, 0);
    chk({nm, "_time"}, time_left, 0);
  endtask

  initial begin
    reset_n = 1'b0; start_btn = 1'b0; level_sel = 2'd0; alavanca1 = '0; alavanca2 = '0;
    repeat (3) @(negedge clock);
    outputs_zero("reset");
    reset_n = 1'b1;
    pulses = 0;
    repeat (8) @(negedge clock);
    chk("idle_no_pulse", pulses, 0);
    chk("idle_playing", playing, 0);
    // win at level 3, diff 500, button held well past the round
    level_sel = 2'd3; alavanca1 = 16'd1000; alavanca2 = 16'd500; pulses = 0; start_btn = 1'b1;
    wait_until(0, 10);
    chk("pulse_seen", start_game, 1);
    repeat (2) @(negedge clock);
    chk("play_two_after_pulse", playing, 1);
    wait_until(2, 60);
    chk("win3_win", win, 1);
    chk("win3_hold", hold_count, 3);
    chk("win3_time", time_left, 7);
    repeat (10) @(negedge clock);
    start_btn = 1'b0;
    chk("single_pulse", pulses, 1);
    chk("win_held", win, 1);
    // restart from WIN: new level ignored, diff 513 just over the level-3 tolerance
    level_sel = 2'd0; alavanca1 = 16'd1013; alavanca2 = 16'd500;
    @(negedge clock);
    start_btn = 1'b1;
    wait_until(0, 10);
    chk("restart_pulse", start_game, 1);
    repeat (2) @(negedge clock);
    start_btn = 1'b0;
    chk("restart_playing", playing, 1);
    chk("restart_time", time_left, 10);
    chk("restart_hold", hold_count, 0);
    wait_until(3, 80);
    chk("b513_lose", lose, 1);
    chk("b513_win", win, 0);
    chk("b513_hold", hold_count, 0);
    chk("b513_time", time_left, 0);
    // asynchronous reset in the middle of a round
    start_btn = 1'b1;
    wait_until(1, 10);
    repeat (2) @(negedge clock);
    chk("midplay_running", playing, 1);
    #1 reset_n = 1'b0;
    #1 outputs_zero("midplay_rst");
    @(negedge clock);
    reset_n = 1'b1; start_btn = 1'b0;
    repeat (2) @(negedge clock);
    // asynchronous reset during the start_game pulse
    start_btn = 1'b1;
    wait_until(0, 10);
    chk("pulse_before_rst", start_game, 1);
    #1 reset_n = 1'b0;
    #1 outputs_zero("pulse_rst");
    @(negedge clock);
    reset_n = 1'b1; start_btn = 1'b0;
    repeat (2) @(negedge clock);
    // level 0 with extreme readings for 7 ticks, then balanced: win and timeout coincide
    level_sel = 2'd0; alavanca1 = 16'h8000; alavanca2 = 16'h7fff;
    start_btn = 1'b1;
    wait_until(0, 10);
    @(negedge clock);
    start_btn = 1'b0;
    wait_until(4, 60);
    chk("extreme_time", time_left, 3);
    chk("extreme_hold", hold_count, 0);
    alavanca1 = 16'd0; alavanca2 = 16'd0;
    wait_until(5, 40);
    chk("tie_win", win, 1);
    chk("tie_lose", lose, 0);
    chk("tie_hold", hold_count, 3);
    chk("tie_time", time_left, 0);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
